// File: rtl/registers.sv
// 32 x 32 integer register file: two combinational read ports, one write per clock edge.
// Entry 0 has no storage and always reads as zero; writes aimed at it are dropped.
module registers #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_register_1,
    input  logic [ADDR_WIDTH-1:0] read_register_2,
    output logic [DATA_WIDTH-1:0] result_1,
    output logic [DATA_WIDTH-1:0] result_2,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] reg_value [NUM_REGS];

    assign reg_value[0] = '0;

    // Each entry is its own flop bank so the async clear reaches all of them at once.
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_d;
            logic [DATA_WIDTH-1:0] entry_q;

            always_comb begin
                entry_d = entry_q;
                if (write_register == ADDR_WIDTH'(gi)) begin
                    entry_d = write_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign reg_value[gi] = entry_q;
        end
    endgenerate

    // No write bypass: a same-cycle write is visible only after the edge.
    always_comb begin
        result_1 = reg_value[read_register_1];
        result_2 = reg_value[read_register_2];
        if (read_register_1 == '0) begin
            result_1 = '0;
        end
        if (read_register_2 == '0) begin
            result_2 = '0;
        end
    end

endmodule

// File: tb/tb_registers.sv
// Directed-vector bench for the registers file; expected values are hand-computed constants.
module tb_registers;

    logic        clk;
    logic        rst;
    logic [4:0]  read_register_1;
    logic [4:0]  read_register_2;
    logic [31:0] result_1;
    logic [31:0] result_2;
    logic [4:0]  write_register;
    logic [31:0] write_data;

    int checks;
    int errors;

    registers #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .read_register_1(read_register_1),
        .read_register_2(read_register_2),
        .result_1       (result_1),
        .result_2       (result_2),
        .write_register (write_register),
        .write_data     (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=%08h", tag, got);
        end
    endtask

    // Present a write at the falling edge, let the rising edge commit it, then park on index 0.
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        write_register = idx;
        write_data     = data;
        @(posedge clk);
        #1;
        write_register = 5'd0;
    endtask

    function automatic logic [31:0] sweep_val(input int i);
        logic [7:0] ib;
        ib = 8'(i);
        return (i == 0) ? 32'h0 : {ib, 8'hA5, 16'h5A5A};
    endfunction

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        read_register_1 = 5'd0;
        read_register_2 = 5'd5;
        write_register  = 'x;
        write_data      = 'x;

        // Undefined write stimulus while held in reset must not disturb anything.
        repeat (3) @(posedge clk);
        #1;
        check("reset_r1_idx0", result_1, 32'h0);
        check("reset_r2_idx5", result_2, 32'h0);
        write_register = 5'd0;
        write_data     = 32'h0;
        @(negedge clk);
        rst = 1'b1;

        // Fill 1..31 with nonzero data, then pulse reset and sweep every index.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'h0101_0101 * i);
        end
        read_register_1 = 5'd3;
        read_register_2 = 5'd31;
        #1;
        check("fill_r1_idx3", result_1, 32'h0303_0303);
        check("fill_r2_idx31", result_2, 32'h1F1F_1F1F);
        @(negedge clk);
        write_register = 5'd9;
        write_data     = 32'h1234_5678;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_register_1 = 5'(i);
            read_register_2 = 5'(31 - i);
            #1;
            check($sformatf("pulse_reset_r1_idx%0d", i), result_1, 32'h0);
            check($sformatf("pulse_reset_r2_idx%0d", 31 - i), result_2, 32'h0);
        end
        write_register = 5'd0;
        write_data     = 32'h0;
        @(negedge clk);
        rst = 1'b1;

        // Write to register 0 is discarded.
        @(negedge clk);
        read_register_1 = 5'd0;
        read_register_2 = 5'd1;
        write_register  = 5'd0;
        write_data      = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check("r0_write_r1", result_1, 32'h0);
        check("r0_write_r2", result_2, 32'h0);

        // Register 1 write, then overwrite.
        @(negedge clk);
        write_register = 5'd1;
        write_data     = 32'hFFFF_FFFF;
        #1;
        check("r1_before_edge", result_2, 32'h0);
        @(posedge clk);
        #1;
        check("r1_after_ffff_r2", result_2, 32'hFFFF_FFFF);
        check("r1_after_ffff_r1", result_1, 32'h0);
        @(negedge clk);
        write_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("r1_after_dead", result_2, 32'hDEAD_BEEF);
        write_register = 5'd0;

        // Read-during-write on the same index returns the old value until the edge.
        write_reg(5'd5, 32'h1111_1111);
        @(negedge clk);
        read_register_1 = 5'd5;
        read_register_2 = 5'd5;
        write_register  = 5'd5;
        write_data      = 32'h2222_2222;
        #1;
        check("rdw_before_r1", result_1, 32'h1111_1111);
        check("rdw_before_r2", result_2, 32'h1111_1111);
        @(posedge clk);
        #1;
        check("rdw_after_r1", result_1, 32'h2222_2222);
        write_register = 5'd0;

        // Full sweep with index-tagged data, read back as mirrored pairs.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), sweep_val(i));
        end
        for (int i = 0; i < 32; i++) begin
            read_register_1 = 5'(i);
            read_register_2 = 5'(31 - i);
            #1;
            check($sformatf("sweep_r1_idx%0d", i), result_1, sweep_val(i));
            check($sformatf("sweep_r2_idx%0d", 31 - i), result_2, sweep_val(31 - i));
        end

        // Asynchronous reset between edges clears without a clock edge.
        write_reg(5'd7, 32'hCAFE_F00D);
        @(negedge clk);
        read_register_1 = 5'd7;
        read_register_2 = 5'd12;
        #2;
        check("async_before_r1", result_1, 32'hCAFE_F00D);
        check("async_before_r2", result_2, sweep_val(12));
        rst = 1'b0;
        #1;
        check("async_after_r1", result_1, 32'h0);
        check("async_after_r2", result_2, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // First edge after release writes normally.
        write_reg(5'd7, 32'h0BAD_F00D);
        #1;
        check("post_release_write", result_1, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
